// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: 16-cycle shift-add multiply or restoring divide,
// with the 17-bit sign-extended result handed to the HI/LO pair on a one-cycle strobe.
module muldiv_unit #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              busy,
    output logic              done,
    output logic              hilo_en,
    output logic              div_zero,
    output logic [DATA_W:0]   hi_data,
    output logic [DATA_W:0]   lo_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic                iterate;

    logic                is_div;
    logic                is_signed;
    logic                res_neg;
    logic                rem_neg;
    logic                dz;
    logic [DATA_W-1:0]   opnd;
    logic [DATA_W-1:0]   rs_raw;
    logic [DATA_W-1:0]   rem;
    logic [2*DATA_W-1:0] acc;

    logic                rs_neg;
    logic                rt_neg;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_acc;
    logic [DATA_W:0]     div_shift;
    logic                div_ge;
    logic [DATA_W-1:0]   div_rem;
    logic [DATA_W-1:0]   div_quo;

    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo_s;
    logic [DATA_W-1:0]   rem_s;
    logic [DATA_W:0]     res_hi;
    logic [DATA_W:0]     res_lo;

    // 0x8000 stays 0x8000 as an unsigned magnitude, so no operand overflows.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [DATA_W:0] sext(input logic [DATA_W-1:0] v, input logic sgn);
        return {sgn & v[DATA_W-1], v};
    endfunction

    assign rs_neg  = op[0] & rs_val[DATA_W-1];
    assign rt_neg  = op[0] & rt_val[DATA_W-1];
    assign iterate = (cnt != CNT_W'(DATA_W));

    assign mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_acc = {mul_sum, acc[DATA_W-1:1]};

    // The true difference is below 2^DATA_W whenever it is kept, so a narrow subtract suffices.
    assign div_shift = {rem, acc[DATA_W-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_rem   = div_ge ? (div_shift[DATA_W-1:0] - opnd) : div_shift[DATA_W-1:0];
    assign div_quo   = {acc[DATA_W-2:0], div_ge};

    always_comb begin
        prod   = res_neg ? -acc : acc;
        quo_s  = res_neg ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        rem_s  = rem_neg ? -rem : rem;
        res_hi = sext(prod[2*DATA_W-1:DATA_W], is_signed);
        res_lo = sext(prod[DATA_W-1:0], is_signed);
        if (is_div) begin
            if (dz) begin
                res_hi = {1'b0, rs_raw};
                res_lo = {1'b0, {DATA_W{1'b1}}};
            end else begin
                res_hi = sext(rem_s, is_signed);
                res_lo = sext(quo_s, is_signed);
            end
        end
    end

    // Operand/accumulator datapath: no reset, only meaningful while busy
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            is_div    <= op[1];
            is_signed <= op[0];
            res_neg   <= rs_neg ^ rt_neg;
            rem_neg   <= rs_neg;
            rs_raw    <= rs_val;
            dz        <= op[1] && (rt_val == '0);
            rem       <= '0;
            if (op[1]) begin
                opnd <= mag(rt_val, rt_neg);
                acc  <= {{DATA_W{1'b0}}, mag(rs_val, rs_neg)};
            end else begin
                opnd <= mag(rs_val, rs_neg);
                acc  <= {{DATA_W{1'b0}}, mag(rt_val, rt_neg)};
            end
        end else if (state == RUN && iterate) begin
            if (is_div) begin
                rem <= div_rem;
                acc <= {{DATA_W{1'b0}}, div_quo};
            end else begin
                acc <= mul_acc;
            end
        end
    end

    // Control and result registers; the extra RUN cycle after the last iteration loads HI/LO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            hi_data <= '0;
            lo_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (iterate) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        state   <= DONE;
                        hi_data <= res_hi;
                        lo_data <= res_lo;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == RUN) || (state == DONE);
    assign done     = (state == DONE);
    assign hilo_en  = (state == DONE);
    assign div_zero = (state == DONE) && dz;

endmodule
